// File: rtl/sram_write_queue.sv
// sram_write_queue: DEPTH-entry FIFO of SRAM write requests, dispatched one at
// a time to the downstream write sequencer over its start/done handshake.
// Optional build macro: SRAM_WRITE_QUEUE_STATS_EN adds the issued_count output.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | wait for a queued entry and an idle sequencer; load + pop head
// ISSUE     | one-cycle fsm_start pulse, address/data already registered
// WAIT_BUSY | wait for the sequencer to drop fsm_done (leave idle)
// WAIT_DONE | wait for the sequencer to raise fsm_done (write finished)
module sram_write_queue #(
  parameter int data_width    = 16,
  parameter int address_width = 16,
  parameter int depth         = 4,
  parameter int ptr_width     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [address_width-1:0] wr_address,
  input  logic [data_width-1:0]    wr_data,
  output logic                     fsm_start,
  output logic [address_width-1:0] fsm_address,
  output logic [data_width-1:0]    fsm_data,
  input  logic                     fsm_done,
  output logic [ptr_width:0]       level
`ifdef SRAM_WRITE_QUEUE_STATS_EN
  ,
  output logic [15:0]              issued_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [address_width-1:0] addr_mem [depth];
  logic [data_width-1:0]    data_mem [depth];
  logic [ptr_width-1:0]     head, tail;
  logic                     push, pop;

  // Full only when level reaches depth; level is separate from the pointers
  // so full and empty never alias.
  assign wr_ready = (level != (ptr_width+1)'(depth));
  assign push     = wr_valid && wr_ready;

  // Storage is not reset; validity is tracked entirely by level.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= wr_address;
      data_mem[tail] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since depth is 2**ptr_width.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + ptr_width'(1);
      if (pop)  head <= head + ptr_width'(1);
      case ({push, pop})
        2'b10:   level <= level + (ptr_width+1)'(1);
        2'b01:   level <= level - (ptr_width+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Head entry is captured on the IDLE->ISSUE edge and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_address <= '0;
      fsm_data    <= '0;
    end else if (pop) begin
      fsm_address <= addr_mem[head];
      fsm_data    <= data_mem[head];
    end
  end

  // Dispatcher state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, pop and start decode; fsm_done is used as a level throughout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fsm_start = 1'b0;
    case (state)
      IDLE: begin
        if ((level != '0) && fsm_done) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fsm_start = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!fsm_done) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fsm_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SRAM_WRITE_QUEUE_STATS_EN
  // Counts dispatches; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)      issued_count <= '0;
    else if (pop) issued_count <= issued_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sram_write_queue.sv
// Testbench for sram_write_queue: directed scenarios plus a randomized phase,
// checked against a queue-based reference and a behavioural sequencer model.
module tb_sram_write_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_address = '0;
  logic [15:0] wr_data = '0;
  logic        fsm_start;
  logic [15:0] fsm_address;
  logic [15:0] fsm_data;
  logic        fsm_done;
  logic [2:0]  level;
`ifdef SRAM_WRITE_QUEUE_STATS_EN
  logic [15:0] issued_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_q[$];
  int n_issued    = 0;
  int n_since_rst = 0;
  bit seq_active  = 1'b0;
  bit seq_hold    = 1'b0;
  int seq_cnt     = 0;
  int exp_level;
  logic [31:0] exp_entry;

  assign fsm_done = !(seq_active || seq_hold);

  sram_write_queue #(
    .data_width(16), .address_width(16), .depth(DEPTH), .ptr_width(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_address(wr_address), .wr_data(wr_data), .fsm_start(fsm_start),
    .fsm_address(fsm_address), .fsm_data(fsm_data), .fsm_done(fsm_done),
    .level(level)
`ifdef SRAM_WRITE_QUEUE_STATS_EN
    , .issued_count(issued_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sequencer model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_level = model_q.size() - (fsm_start ? 1 : 0);
      check("level", level, exp_level);
      check("wr_ready", wr_ready, exp_level != DEPTH);
      if (fsm_start) begin
        check("start_while_busy", seq_active, 1'b0);
        if (model_q.size() == 0) begin
          check("start_unexpected", fsm_start, 1'b0);
        end else begin
          exp_entry = model_q.pop_front();
          check("issue_addr", fsm_address, exp_entry[31:16]);
          check("issue_data", fsm_data, exp_entry[15:0]);
        end
        n_issued++;
        n_since_rst++;
        seq_active = 1'b1;
        seq_cnt    = $urandom_range(2, 5);
      end else if (seq_active) begin
        if (seq_cnt > 0) seq_cnt--;
        if (seq_cnt == 0 && !seq_hold) seq_active = 1'b0;
      end
    end
  end

  // Entered just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic [15:0] a, input logic [15:0] d);
    int c;
    wr_valid   = 1'b1;
    wr_address = a;
    wr_data    = d;
    c = 0;
    while (!wr_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!wr_ready) check("push_timeout", wr_ready, 1'b1);
    @(posedge clk);
    if (wr_ready) model_q.push_back({a, d});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (!(model_q.size() == 0 && !seq_active && level == 0) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_complete", (model_q.size() == 0 && !seq_active) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_q.delete();
    n_since_rst = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_level", level, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_start", fsm_start, 0);
    check("rst_addr", fsm_address, 0);
    check("rst_data", fsm_data, 0);

    // single push: start exactly two cycles after the push edge
    push(16'h0010, 16'hBEEF);
    check("t1_level_n1", level, 1);
    check("t1_start_n1", fsm_start, 0);
    @(negedge clk);
    check("t1_start_n2", fsm_start, 1);
    check("t1_addr", fsm_address, 16'h0010);
    check("t1_data", fsm_data, 16'hBEEF);
    check("t1_level_n2", level, 0);
    @(negedge clk);
    check("t1_start_n3", fsm_start, 0);
    drain();

    // fill with sequencer busy, hold off a fifth push, then drain in order
    seq_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), 16'(($urandom)));
    check("t2_level_full", level, 4);
    check("t2_ready_full", wr_ready, 0);
    wr_valid   = 1'b1;
    wr_address = 16'h0104;
    wr_data    = 16'h5A5A;
    repeat (3) @(negedge clk);
    check("t2_level_held", level, 4);
    seq_hold = 1'b0;
    push(16'h0104, 16'h5A5A);
    drain();

    // simultaneous push and pop at level 2
    seq_hold = 1'b1;
    @(negedge clk);
    push(16'h0200, 16'h1111);
    push(16'h0201, 16'h2222);
    check("t4_level_pre", level, 2);
    seq_hold = 1'b0;
    push(16'h0202, 16'h3333);
    check("t4_level_post", level, 2);
    drain();

    // randomized traffic, covers pointer wrap many times
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0) push(16'($urandom), 16'($urandom));
      else @(negedge clk);
    end
    drain();

    // reset during WAIT_DONE with three entries queued
    prev = n_issued;
    for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 16'h0A00 + 16'(i));
    for (int c = 0; c < 50 && n_issued == prev; c++) @(negedge clk);
    check("t5_first_issue", n_issued, prev + 1);
    seq_hold = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_level_pre", level, 3);
    do_reset();
    check("t5_level_rst", level, 0);
    check("t5_start_rst", fsm_start, 0);
    check("t5_ready_rst", wr_ready, 1);
    check("t5_addr_rst", fsm_address, 0);
    prev = n_issued;
    push(16'h0400, 16'hC0DE);
    repeat (6) @(negedge clk);
    check("t5_no_issue_busy", n_issued, prev);
    seq_hold = 1'b0;
    drain();
    check("t5_issued_after", n_issued, prev + 1);

`ifdef SRAM_WRITE_QUEUE_STATS_EN
    for (int i = 0; i < 4; i++) push(16'h0500 + 16'(i), 16'(($urandom)));
    drain();
    check("stats_count", issued_count, n_since_rst);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
